alu_operand_issue: RTL and testbench



---
 rtl/alu_defs.sv | 28 ++
 rtl/skid_entry.sv | 29 ++
 rtl/alu_operand_issue.sv | 136 +++++++++++++
 tb/tb_alu_operand_issue.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// Shared definitions for the ALU operand-issue stage.
//   - ALU opcode encodings used by the decode side and the ALU.
//   - Default datapath widths.
//   - Occupancy states of the operand-issue skid buffer.
package alu_defs;

    localparam int WIDTH_DEF = 32;
    localparam int OPW_DEF   = 3;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_XOR  = 3'd2,
        OP_SLT  = 3'd3,
        OP_AND  = 3'd4,
        OP_NAND = 3'd5,
        OP_NOR  = 3'd6,
        OP_OR   = 3'd7
    } alu_op_e;

    // Occupancy of the two-entry buffer (head + skid).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/skid_entry.sv
// One buffer entry: a plain W-bit register with load enable.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears to 0)
//   load_i     : capture d_i on this edge
//   d_i        : next contents
//   q_o        : current contents
module skid_entry #(
    parameter int W = 67
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/alu_operand_issue.sv
// Registered operand-issue stage in front of the 32-bit ALU / SLT datapath.
// A two-entry buffer (head feeds the ALU, skid absorbs one extra op) lets
// in_ready come straight from a flop while still sustaining 1 op/cycle.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : upstream handshake (in_ready registered)
//   in_a, in_b, in_op    : operands and opcode from decode/register read
//   flush                : drop everything buffered, accepted input included
//   alu_valid/alu_ready  : downstream handshake to the ALU
//   alu_a, alu_b, alu_op : head entry, held stable while stalled
//   slt_issued           : wrapping count of SLT ops handed to the ALU
module alu_operand_issue
    import alu_defs::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OPW-1:0]   in_op,
    input  logic             flush,
    output logic             alu_valid,
    input  logic             alu_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    output logic [CNTW-1:0]  slt_issued
);

    localparam int EW = 2*WIDTH + OPW;

    occ_e            state_q, state_d;
    logic            in_ready_q, alu_valid_q;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [EW-1:0]   in_ent, head_q, skid_q, head_d;
    logic            head_ld, skid_ld, head_from_skid;
    logic            in_xfer, out_xfer;

    assign in_ent   = {in_a, in_b, in_op};
    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = alu_valid_q && alu_ready;

    always_comb begin
        state_d        = state_q;
        head_ld        = 1'b0;
        skid_ld        = 1'b0;
        head_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d = ST_ONE;
                    head_ld = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    head_ld = 1'b1;
                end else if (in_xfer) begin
                    state_d = ST_FULL;
                    skid_ld = 1'b1;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so no input can arrive.
                if (out_xfer) begin
                    state_d        = ST_ONE;
                    head_ld        = 1'b1;
                    head_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush discards a same-cycle input; alu_* may keep stale contents.
        if (flush) begin
            state_d = ST_EMPTY;
            head_ld = 1'b0;
            skid_ld = 1'b0;
        end
    end

    assign head_d = head_from_skid ? skid_q : in_ent;

    // An output transfer still counts even when flush lands in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (out_xfer && (head_q[OPW-1:0] == OPW'(OP_SLT))) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            alu_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_FULL);
            alu_valid_q <= (state_d != ST_EMPTY);
            cnt_q       <= cnt_d;
        end
    end

    skid_entry #(.W(EW)) u_head (
        .clk    (clk),
        .reset  (reset),
        .load_i (head_ld),
        .d_i    (head_d),
        .q_o    (head_q)
    );

    skid_entry #(.W(EW)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load_i (skid_ld),
        .d_i    (in_ent),
        .q_o    (skid_q)
    );

    assign in_ready   = in_ready_q;
    assign alu_valid  = alu_valid_q;
    assign alu_a      = head_q[EW-1 -: WIDTH];
    assign alu_b      = head_q[OPW +: WIDTH];
    assign alu_op     = head_q[OPW-1:0];
    assign slt_issued = cnt_q;

endmodule

// File: tb/tb_alu_operand_issue.sv
module tb_alu_operand_issue;
    import alu_defs::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, flush, alu_ready;
    logic [31:0] in_a, in_b;
    logic [2:0]  in_op;

    logic        in_ready, alu_valid;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [15:0] slt_issued;

    logic        in_ready4, alu_valid4;
    logic [31:0] alu_a4, alu_b4;
    logic [2:0]  alu_op4;
    logic [3:0]  slt_issued4;

    alu_operand_issue #(.WIDTH(32), .OPW(3), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .flush(flush),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_a(alu_a),
        .alu_b(alu_b), .alu_op(alu_op), .slt_issued(slt_issued)
    );

    // Same stimulus, narrow counter for the wrap check.
    alu_operand_issue #(.WIDTH(32), .OPW(3), .CNTW(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .flush(flush),
        .alu_valid(alu_valid4), .alu_ready(alu_ready), .alu_a(alu_a4),
        .alu_b(alu_b4), .alu_op(alu_op4), .slt_issued(slt_issued4)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } ent_t;

    ent_t        sb[$];
    logic [15:0] m_cnt  = '0;
    logic [3:0]  m_cnt4 = '0;
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: compare outputs against the scoreboard, drive inputs,
    // then advance the scoreboard by what transfers on the coming edge.
    task automatic cyc(input logic rst, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] op,
                       input logic rdy, input logic fl);
        ent_t e;
        logic in_x, out_x;
        @(negedge clk);
        reset = rst; in_valid = v; in_a = a; in_b = b; in_op = op;
        alu_ready = rdy; flush = fl;
        chk("in_ready",    {63'd0, in_ready},   {63'd0, sb.size() < 2});
        chk("in_ready4",   {63'd0, in_ready4},  {63'd0, sb.size() < 2});
        chk("alu_valid",   {63'd0, alu_valid},  {63'd0, sb.size() > 0});
        chk("alu_valid4",  {63'd0, alu_valid4}, {63'd0, sb.size() > 0});
        chk("slt_issued",  {48'd0, slt_issued}, {48'd0, m_cnt});
        chk("slt_issued4", {60'd0, slt_issued4}, {60'd0, m_cnt4});
        if (rst) begin
            sb.delete();
            m_cnt  = '0;
            m_cnt4 = '0;
        end else begin
            in_x  = v && (sb.size() < 2);
            out_x = rdy && (sb.size() > 0);
            if (out_x) begin
                e = sb.pop_front();
                chk("alu_a",  {32'd0, alu_a},  {32'd0, e.a});
                chk("alu_b",  {32'd0, alu_b},  {32'd0, e.b});
                chk("alu_op", {61'd0, alu_op}, {61'd0, e.op});
                if (e.op == OP_SLT) begin
                    m_cnt  = m_cnt + 16'd1;
                    m_cnt4 = m_cnt4 + 4'd1;
                end
            end
            if (fl) sb.delete();
            else if (in_x) sb.push_back({a, b, op});
        end
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, rdy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b1; flush = 1'b0; alu_ready = 1'b0;
        in_a = 32'hdead_beef; in_b = 32'h1234_5678; in_op = 3'd3;
        repeat (2) @(posedge clk);

        // Reset held with in_valid high, then first cycle out of reset.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 32'hffff_ffff, 32'h1, 3'd3, 1'b1, 1'b0);
        idle(1'b1, 1);

        // Single SLT.
        cyc(1'b0, 1'b1, 32'h8000_0100, 32'h0208_2100, 3'd3, 1'b1, 1'b0);
        idle(1'b1, 3);
        chk("single_slt_cnt", {48'd0, slt_issued}, 64'd1);

        // Back-pressure: X, Y accepted, third push refused while full.
        cyc(1'b0, 1'b1, 32'h1111_1111, 32'h2222_2222, 3'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h3333_3333, 32'h4444_4444, 3'd3, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h5555_5555, 32'h6666_6666, 3'd7, 1'b0, 1'b0);
        idle(1'b0, 2);
        idle(1'b1, 3);

        // Streaming 8 ops, opcode 0..7.
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b1, 32'hA000_0000 + 32'(i), 32'hB000_0000 - 32'(i), 3'(i), 1'b1, 1'b0);
        idle(1'b1, 3);
        chk("stream_cnt", {48'd0, slt_issued}, 64'd3);

        // Flush while full with a simultaneous output (SLT) and input.
        cyc(1'b0, 1'b1, 32'hC0C0_C0C0, 32'h0101_0101, 3'd3, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'hD0D0_D0D0, 32'h0202_0202, 3'd1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'hE0E0_E0E0, 32'h0303_0303, 3'd2, 1'b1, 1'b1);
        idle(1'b1, 3);
        chk("flush_cnt", {48'd0, slt_issued}, 64'd4);

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++)
            cyc(1'b0, 1'($urandom % 2), $urandom, $urandom, 3'($urandom % 8),
                1'($urandom_range(0, 3) != 0), 1'($urandom % 25 == 0));
        idle(1'b1, 3);

        // Counter wrap: 17 SLT ops on the 4-bit counter.
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++)
            cyc(1'b0, 1'b1, 32'(i), 32'(i * 3), 3'd3, 1'b1, 1'b0);
        idle(1'b1, 3);
        chk("wrap_cnt4", {60'd0, slt_issued4}, 64'd1);
        chk("wrap_cnt16", {48'd0, slt_issued}, 64'd17);
        if (sb.size() != 0) chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
